// File: rtl/rowo_dpram.sv
// rowo_dpram -- single-clock, one-write-port / one-read-port RAM with
// independent port widths.  The write port (wdw bits) and the read port
// (rdw bits) view the same rdw*2^raw bits of storage; their widths may
// differ by a power-of-two ratio of 1, 2, 4 or 8.  Lanes are little-endian:
// the lowest write address inside a read word occupies the lowest bits.
//
// Ports
//   clk        rising-edge clock shared by both ports
//   rst        synchronous, active-low reset (clears q, blocks writes,
//              memory contents are left untouched)
//   data       write data, wdw bits
//   wraddress  write word address, waw bits
//   wren       write enable
//   rdaddress  read word address, raw bits
//   rden       read enable; q holds when low
//   q          registered read data, rdw bits, one cycle after rdaddress
//
// Read-during-write to the same location returns the pre-write contents.

module rowo_dpram #(
   parameter int rdw = 32,
   parameter int raw = 4,
   parameter int wdw = 32,
   localparam int ratio = (rdw >= wdw) ? rdw / wdw : wdw / rdw,
   localparam int lg    = $clog2(ratio),
   localparam int waw   = (rdw >= wdw) ? raw + lg : raw - lg
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [wdw-1:0] data,
   input  logic [waw-1:0] wraddress,
   input  logic           wren,
   input  logic [raw-1:0] rdaddress,
   input  logic           rden,
   output logic [rdw-1:0] q
);

   // Physical words are as wide as the wider port, so every access touches
   // exactly one physical word: narrow writes become lane writes, narrow
   // reads become a lane select ahead of the output register.
   localparam int mw = (rdw >= wdw) ? rdw : wdw;
   localparam int ma = (rdw >= wdw) ? raw : waw;

   localparam bit ratio_ok =
      (rdw > 0) && (wdw > 0) &&
      ((rdw >= wdw) ? (rdw == ratio * wdw) : (wdw == ratio * rdw)) &&
      (ratio == 1 || ratio == 2 || ratio == 4 || ratio == 8) &&
      ((rdw >= wdw) || (raw > lg));

   generate
      if (!ratio_ok) begin : g_bad_ratio
         $error("rowo_dpram: port width ratio must be 1, 2, 4 or 8 (rdw=%0d wdw=%0d raw=%0d)",
                rdw, wdw, raw);
      end
   endgenerate

   logic [mw-1:0] mem [2**ma];

   generate
      if (lg == 0) begin : g_equal
         always_ff @(posedge clk) begin
            if (rst && wren)
               mem[wraddress] <= data;
         end

         always_ff @(posedge clk) begin
            if (!rst)
               q <= '0;
            else if (rden)
               q <= mem[rdaddress];
         end
      end else if (rdw > wdw) begin : g_narrow_wr
         // Upper write-address bits pick the row, lower bits pick the lane.
         logic [raw-1:0] wrow;
         logic [lg-1:0]  wlane;

         assign wrow  = wraddress[waw-1:lg];
         assign wlane = wraddress[lg-1:0];

         always_ff @(posedge clk) begin
            if (rst && wren) begin
               for (int k = 0; k < ratio; k++) begin
                  if (wlane == lg'(k))
                     mem[wrow][k*wdw +: wdw] <= data;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!rst)
               q <= '0;
            else if (rden)
               q <= mem[rdaddress];
         end
      end else begin : g_wide_wr
         // Upper read-address bits pick the row, lower bits pick the lane.
         logic [waw-1:0] rrow;
         logic [lg-1:0]  rlane;

         assign rrow  = rdaddress[raw-1:lg];
         assign rlane = rdaddress[lg-1:0];

         always_ff @(posedge clk) begin
            if (rst && wren)
               mem[wraddress] <= data;
         end

         always_ff @(posedge clk) begin
            if (!rst)
               q <= '0;
            else if (rden) begin
               for (int k = 0; k < ratio; k++) begin
                  if (rlane == lg'(k))
                     q <= mem[rrow][k*rdw +: rdw];
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_rowo_dpram.sv
// Bench for rowo_dpram.  Three instances share clk/rst:
//   A: rdw=32 wdw=32 raw=4   (equal widths)
//   B: rdw=32 wdw=8  raw=4   (narrow writes, waw=6)
//   C: rdw=8  wdw=32 raw=6   (wide writes,  waw=4)
// The reference model stores B and C as flat byte arrays (little-endian
// lanes) and A as a word array, with a per-location "written" flag so
// locations never written are not compared.

module tb_rowo_dpram;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [31:0] da;  logic [3:0] wa;  logic [3:0] ra;  logic wea, rea;  logic [31:0] qa;
   logic [7:0]  db;  logic [5:0] wb;  logic [3:0] rb;  logic web, reb;  logic [31:0] qb;
   logic [31:0] dc;  logic [3:0] wc;  logic [5:0] rc;  logic wec, rec;  logic [7:0]  qc;

   rowo_dpram #(.rdw(32), .raw(4), .wdw(32)) u_a (
      .clk(clk), .rst(rst), .data(da), .wraddress(wa), .wren(wea),
      .rdaddress(ra), .rden(rea), .q(qa));

   rowo_dpram #(.rdw(32), .raw(4), .wdw(8)) u_b (
      .clk(clk), .rst(rst), .data(db), .wraddress(wb), .wren(web),
      .rdaddress(rb), .rden(reb), .q(qb));

   rowo_dpram #(.rdw(8), .raw(6), .wdw(32)) u_c (
      .clk(clk), .rst(rst), .data(dc), .wraddress(wc), .wren(wec),
      .rdaddress(rc), .rden(rec), .q(qc));

   // reference model
   logic [31:0] a_mem [16];  bit a_ok [16];
   logic [7:0]  b_mem [64];  bit b_ok [64];
   logic [7:0]  c_mem [64];  bit c_ok [64];
   logic [31:0] ea, eb;
   logic [7:0]  ec;
   bit          ea_ok, eb_ok, ec_ok;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock: update the model from the inputs presented now,
   // then compare every instance whose expected q is known.
   task automatic tick();
      if (!rst) begin
         ea = '0; eb = '0; ec = '0;
         ea_ok = 1'b1; eb_ok = 1'b1; ec_ok = 1'b1;
      end else begin
         // reads see contents before this cycle's writes
         if (rea) begin
            ea    = a_mem[ra];
            ea_ok = a_ok[ra];
         end
         if (reb) begin
            eb_ok = 1'b1;
            for (int k = 0; k < 4; k++) begin
               eb[8*k +: 8] = b_mem[4*int'(rb) + k];
               if (!b_ok[4*int'(rb) + k]) eb_ok = 1'b0;
            end
         end
         if (rec) begin
            ec    = c_mem[rc];
            ec_ok = c_ok[rc];
         end
         if (wea) begin
            a_mem[wa] = da;
            a_ok[wa]  = 1'b1;
         end
         if (web) begin
            b_mem[wb] = db;
            b_ok[wb]  = 1'b1;
         end
         if (wec) begin
            for (int k = 0; k < 4; k++) begin
               c_mem[4*int'(wc) + k] = dc[8*k +: 8];
               c_ok[4*int'(wc) + k]  = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      if (ea_ok) chk("model_q_a", qa, ea);
      if (eb_ok) chk("model_q_b", qb, eb);
      if (ec_ok) chk("model_q_c", {24'h0, qc}, {24'h0, ec});
   endtask

   task automatic idle_all();
      wea = 1'b0; rea = 1'b0;
      web = 1'b0; reb = 1'b0;
      wec = 1'b0; rec = 1'b0;
   endtask

   initial begin
      ea_ok = 1'b0; eb_ok = 1'b0; ec_ok = 1'b0;
      ea = '0; eb = '0; ec = '0;
      da = '0; wa = '0; ra = '0;
      db = '0; wb = '0; rb = '0;
      dc = '0; wc = '0; rc = '0;
      idle_all();

      // reset for two cycles with write enables high: writes must be dropped
      rst = 1'b0;
      wea = 1'b1; web = 1'b1; wec = 1'b1;
      da = 32'hBAD0_BAD0; db = 8'hBD; dc = 32'hBAD1_BAD1;
      tick();
      tick();
      chk("rst_q_a", qa, 32'h0);
      chk("rst_q_b", qb, 32'h0);
      chk("rst_q_c", {24'h0, qc}, 32'h0);
      rst = 1'b1;
      idle_all();

      // equal widths: fill 0..9 then read back
      for (int i = 0; i < 10; i++) begin
         wea = 1'b1; wa = 4'(i); da = 32'(i) * 32'h1111_1111;
         tick();
      end
      wea = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rea = 1'b1; ra = 4'(i);
         tick();
         chk($sformatf("seq_read_%0d", i), qa, 32'(i) * 32'h1111_1111);
      end

      // read-during-write to the same address returns old data
      wea = 1'b1; wa = 4'd3; da = 32'hDEAD_BEEF;
      rea = 1'b1; ra = 4'd3;
      tick();
      chk("rdw_old", qa, 32'h3333_3333);
      wea = 1'b0;
      tick();
      chk("rdw_new", qa, 32'hDEAD_BEEF);

      // q holds while rden is low
      rea = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ra = 4'($urandom_range(0, 15));
         tick();
         chk($sformatf("hold_%0d", i), qa, 32'hDEAD_BEEF);
      end

      // narrow writes into a wide read word
      for (int i = 0; i < 4; i++) begin
         web = 1'b1; wb = 6'(4 + i); db = 8'(8'h11 * (i + 1));
         tick();
      end
      web = 1'b0; reb = 1'b1; rb = 4'd1;
      tick();
      chk("lanes_full", qb, 32'h4433_2211);
      web = 1'b1; wb = 6'd5; db = 8'hAA; reb = 1'b0;
      tick();
      web = 1'b0; reb = 1'b1; rb = 4'd1;
      tick();
      chk("lanes_partial", qb, 32'h4433_AA11);
      reb = 1'b0;

      // wide write spread over narrow read words
      wec = 1'b1; wc = 4'd2; dc = 32'h4433_2211;
      tick();
      wec = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rec = 1'b1; rc = 6'(8 + i);
         tick();
         chk($sformatf("wide_split_%0d", i), {24'h0, qc}, 32'(8'h11 * (i + 1)));
      end
      rec = 1'b0;

      // reset mid-stream drops the write presented in the reset cycle
      wea = 1'b1; wa = 4'd2; da = 32'h5555_5555; rea = 1'b0;
      tick();
      rst = 1'b0;
      wea = 1'b1; wa = 4'd2; da = 32'h6666_6666; rea = 1'b1; ra = 4'd2;
      tick();
      chk("midrst_q", qa, 32'h0);
      rst = 1'b1; wea = 1'b0; rea = 1'b1; ra = 4'd2;
      tick();
      chk("midrst_keep", qa, 32'h5555_5555);
      idle_all();

      // fill every location of every instance so random reads are defined
      for (int i = 0; i < 64; i++) begin
         wea = (i < 16); wa = 4'(i); da = $urandom;
         web = 1'b1;     wb = 6'(i); db = 8'($urandom);
         wec = (i < 16); wc = 4'(i); dc = $urandom;
         tick();
      end

      // random traffic on all ports with occasional reset
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 31) != 0);
         wea = 1'($urandom); wa = 4'($urandom); da = $urandom;
         rea = 1'($urandom); ra = 4'($urandom);
         web = 1'($urandom); wb = 6'($urandom); db = 8'($urandom);
         reb = 1'($urandom); rb = 4'($urandom);
         wec = 1'($urandom); wc = 4'($urandom); dc = $urandom;
         rec = 1'($urandom); rc = 6'($urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
